// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_SCANOUT = 1'b0;
    localparam logic PORT_DRAWER  = 1'b1;

    localparam int WAIT_CNT_W = 10;

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] data;
        logic [3:0]  wmask;
    } arb_req_t;

endpackage

// File: rtl/sdram_arb_req_slot.sv
// One-deep pending request slot for a single arbiter port, with overflow detection.
module sdram_arb_req_slot
    import sdram_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] addr,
    input  logic        rw,
    input  logic [31:0] data,
    input  logic [3:0]  wmask,
    input  logic        clear,
    output logic        pending,
    output arb_req_t    req,
    output logic        overflow
);

    // A pulse arriving while the slot is full is dropped; the slot keeps the older request.
    assign overflow = in_valid && pending;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending <= 1'b0;
            req     <= '0;
        end else if (in_valid && !pending) begin
            pending    <= 1'b1;
            req.addr   <= addr;
            req.rw     <= rw;
            req.data   <= data;
            req.wmask  <= wmask;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM arbiter (scanout / frame drawer) with wait timeout and sticky error flags.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] rq0_addr,
    input  logic        rq0_rw,
    input  logic [31:0] rq0_data_in,
    input  logic [3:0]  rq0_wmask,
    input  logic        rq0_in_valid,
    output logic [31:0] rq0_data_out,
    output logic        rq0_done,

    input  logic [31:0] rq1_addr,
    input  logic        rq1_rw,
    input  logic [31:0] rq1_data_in,
    input  logic [3:0]  rq1_wmask,
    input  logic        rq1_in_valid,
    output logic [31:0] rq1_data_out,
    output logic        rq1_done,

    output logic [31:0] sd_addr,
    output logic        sd_rw,
    output logic [31:0] sd_data_in,
    output logic [3:0]  sd_wmask,
    output logic        sd_in_valid,
    input  logic [31:0] sd_data_out,
    input  logic        sd_done,

    output logic        err_timeout,
    output logic        err_overflow
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT - 1);

    arb_state_t            state;
    logic                  grant;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  pending0, pending1;
    logic                  overflow0, overflow1;
    logic                  clear0, clear1;
    logic                  finish;
    logic                  next_grant;
    arb_req_t              slot0, slot1, grant_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_grant;
`endif

    sdram_arb_req_slot u_slot0 (
        .clock    (clock),
        .reset    (reset),
        .in_valid (rq0_in_valid),
        .addr     (rq0_addr),
        .rw       (rq0_rw),
        .data     (rq0_data_in),
        .wmask    (rq0_wmask),
        .clear    (clear0),
        .pending  (pending0),
        .req      (slot0),
        .overflow (overflow0)
    );

    sdram_arb_req_slot u_slot1 (
        .clock    (clock),
        .reset    (reset),
        .in_valid (rq1_in_valid),
        .addr     (rq1_addr),
        .rw       (rq1_rw),
        .data     (rq1_data_in),
        .wmask    (rq1_wmask),
        .clear    (clear1),
        .pending  (pending1),
        .req      (slot1),
        .overflow (overflow1)
    );

    // A transaction ends either on sd_done or when the wait budget runs out.
    assign finish = (state == ST_WAIT) && (sd_done || (wait_cnt >= WAIT_LIMIT));
    assign clear0 = finish && (grant == PORT_SCANOUT);
    assign clear1 = finish && (grant == PORT_DRAWER);

    always_comb begin
        next_grant = PORT_SCANOUT;
`ifdef ARB_ROUND_ROBIN_EN
        if (pending0 && pending1) begin
            next_grant = ~last_grant;
        end else if (pending1) begin
            next_grant = PORT_DRAWER;
        end
`else
        if (!pending0 && pending1) begin
            next_grant = PORT_DRAWER;
        end
`endif
    end

    assign grant_req = (next_grant == PORT_DRAWER) ? slot1 : slot0;

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant <= PORT_DRAWER;
        end else if (state == ST_IDLE && (pending0 || pending1)) begin
            last_grant <= next_grant;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_IDLE;
            grant        <= PORT_SCANOUT;
            wait_cnt     <= '0;
            sd_addr      <= '0;
            sd_rw        <= 1'b0;
            sd_data_in   <= '0;
            sd_wmask     <= '0;
            sd_in_valid  <= 1'b0;
            rq0_data_out <= '0;
            rq1_data_out <= '0;
            rq0_done     <= 1'b0;
            rq1_done     <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            sd_in_valid <= 1'b0;
            rq0_done    <= 1'b0;
            rq1_done    <= 1'b0;
            if (overflow0 || overflow1) begin
                err_overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pending0 || pending1) begin
                        grant       <= next_grant;
                        sd_addr     <= grant_req.addr;
                        sd_rw       <= grant_req.rw;
                        sd_data_in  <= grant_req.data;
                        sd_wmask    <= grant_req.wmask;
                        sd_in_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A timed-out transaction still completes, but with zeroed read data.
                    if (sd_done) begin
                        if (grant == PORT_SCANOUT) begin
                            rq0_data_out <= sd_data_out;
                            rq0_done     <= 1'b1;
                        end else begin
                            rq1_data_out <= sd_data_out;
                            rq1_done     <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (wait_cnt >= WAIT_LIMIT) begin
                        err_timeout <= 1'b1;
                        if (grant == PORT_SCANOUT) begin
                            rq0_data_out <= '0;
                            rq0_done     <= 1'b1;
                        end else begin
                            rq1_data_out <= '0;
                            rq1_done     <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, directed corner cases, random traffic vs. a timeline model.
module tb_sdram_port_arbiter;

    localparam int MAXW = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rq0_addr, rq0_data_in, rq0_data_out;
    logic        rq0_rw, rq0_in_valid, rq0_done;
    logic [3:0]  rq0_wmask;
    logic [31:0] rq1_addr, rq1_data_in, rq1_data_out;
    logic        rq1_rw, rq1_in_valid, rq1_done;
    logic [3:0]  rq1_wmask;
    logic [31:0] sd_addr, sd_data_in, sd_data_out;
    logic        sd_rw, sd_in_valid, sd_done;
    logic [3:0]  sd_wmask;
    logic        err_timeout, err_overflow;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] data;
        logic [3:0]  wmask;
        int          lat;
        logic [31:0] rdata;
        int          expDone;
        logic [31:0] expData;
        logic        expTimeout;
    } vec_t;

    vec_t vecs [6];

    always #5 clock = ~clock;

    sdram_port_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clock        (clock),
        .reset        (reset),
        .rq0_addr     (rq0_addr),
        .rq0_rw       (rq0_rw),
        .rq0_data_in  (rq0_data_in),
        .rq0_wmask    (rq0_wmask),
        .rq0_in_valid (rq0_in_valid),
        .rq0_data_out (rq0_data_out),
        .rq0_done     (rq0_done),
        .rq1_addr     (rq1_addr),
        .rq1_rw       (rq1_rw),
        .rq1_data_in  (rq1_data_in),
        .rq1_wmask    (rq1_wmask),
        .rq1_in_valid (rq1_in_valid),
        .rq1_data_out (rq1_data_out),
        .rq1_done     (rq1_done),
        .sd_addr      (sd_addr),
        .sd_rw        (sd_rw),
        .sd_data_in   (sd_data_in),
        .sd_wmask     (sd_wmask),
        .sd_in_valid  (sd_in_valid),
        .sd_data_out  (sd_data_out),
        .sd_done      (sd_done),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        rq0_in_valid = 1'b0; rq1_in_valid = 1'b0;
        sd_done      = 1'b0; sd_data_out  = '0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        idleInputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic driveReq(input int port, input logic [31:0] addr, input logic rw,
                            input logic [31:0] data, input logic [3:0] wmask, input logic valid);
        if (port == 0) begin
            rq0_addr = addr; rq0_rw = rw; rq0_data_in = data; rq0_wmask = wmask; rq0_in_valid = valid;
        end else begin
            rq1_addr = addr; rq1_rw = rw; rq1_data_in = data; rq1_wmask = wmask; rq1_in_valid = valid;
        end
    endtask

    task automatic pulseRequest(input int port, input logic [31:0] addr, input logic rw,
                                input logic [31:0] data, input logic [3:0] wmask);
        driveReq(port, addr, rw, data, wmask, 1'b1);
        tick();
        rq0_in_valid = 1'b0;
        rq1_in_valid = 1'b0;
    endtask

    // Counts cycles until sd_in_valid is seen, giving up after 20 cycles.
    task automatic awaitIssue(input int start, output int cycles);
        cycles = start;
        while (!sd_in_valid && cycles < start + 20) begin
            tick();
            cycles++;
        end
    endtask

    // Starting in the issue cycle: sd_done after lat cycles (never if lat > MAXW), then wait for the port's done.
    task automatic completeTxn(input int port, input int lat, input logic [31:0] rdata,
                               output int k, output int extraIssues);
        logic seen;
        seen = 1'b0;
        k = 0;
        extraIssues = 0;
        while (!seen && k < 40) begin
            if (k == lat) begin
                sd_done = 1'b1;
                sd_data_out = rdata;
            end
            tick();
            k++;
            sd_done = 1'b0;
            if (sd_in_valid) extraIssues++;
            seen = (port == 0) ? rq0_done : rq1_done;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int c, k, x;
        string tag;
        tag = $sformatf("vec%0d", idx);
        pulseRequest(v.port, v.addr, v.rw, v.data, v.wmask);
        awaitIssue(1, c);
        checkOutput({tag, "_issueLat"}, c, 2);
        checkOutput({tag, "_sdAddr"}, sd_addr, v.addr);
        checkOutput({tag, "_sdRw"}, sd_rw, v.rw);
        checkOutput({tag, "_sdData"}, sd_data_in, v.data);
        checkOutput({tag, "_sdMask"}, sd_wmask, v.wmask);
        completeTxn(v.port, v.lat, v.rdata, k, x);
        checkOutput({tag, "_doneLat"}, k, v.expDone);
        checkOutput({tag, "_singleIssue"}, x, 0);
        checkOutput({tag, "_dataOut"}, (v.port == 0) ? rq0_data_out : rq1_data_out, v.expData);
        checkOutput({tag, "_otherDone"}, (v.port == 0) ? rq1_done : rq0_done, 0);
        checkOutput({tag, "_sdAddrHeld"}, sd_addr, v.addr);
        checkOutput({tag, "_timeout"}, err_timeout, v.expTimeout);
    endtask

    // Timeline reference model: a grant seen in an idle cycle j issues at j+1 and completes at
    // issue + 1 + min(latency, MAXW); data is zero when the latency exceeds the wait budget.
    task automatic runRandom(input int cycles);
        logic        mPend [2];
        logic [31:0] mAddr [2], mData [2];
        logic        mRw [2];
        logic [3:0]  mMask [2];
        logic [31:0] expOut [2];
        logic        expDone [2];
        logic        busy, expTo, expOv, ovNext, inWait, v0, v1, vIn;
        int          gPort, issueCyc, doneCyc, lat, lastG, p;
        logic [31:0] rdata, a, d;
        logic        r;
        logic [3:0]  m;

        for (int i = 0; i < 2; i++) begin
            mPend[i] = 1'b0; expOut[i] = '0;
            mAddr[i] = '0; mData[i] = '0; mRw[i] = 1'b0; mMask[i] = '0;
        end
        busy = 1'b0; expTo = 1'b0; expOv = 1'b0; ovNext = 1'b0;
        gPort = 0; issueCyc = 0; doneCyc = 0; lat = 0; lastG = 1; rdata = '0;

        for (int cyc = 0; cyc < cycles; cyc++) begin
            expDone[0] = 1'b0;
            expDone[1] = 1'b0;
            if (busy && cyc == doneCyc) begin
                expDone[gPort] = 1'b1;
                expOut[gPort]  = (lat <= MAXW) ? rdata : 32'h0;
                if (lat > MAXW) expTo = 1'b1;
                mPend[gPort] = 1'b0;
                busy = 1'b0;
            end
            if (ovNext) expOv = 1'b1;
            ovNext = 1'b0;

            checkOutput("rndDone0", rq0_done, expDone[0]);
            checkOutput("rndDone1", rq1_done, expDone[1]);
            checkOutput("rndOut0", rq0_data_out, expOut[0]);
            checkOutput("rndOut1", rq1_data_out, expOut[1]);
            checkOutput("rndTimeout", err_timeout, expTo);
            checkOutput("rndOverflow", err_overflow, expOv);
            checkOutput("rndSdValid", sd_in_valid, busy && cyc == issueCyc);
            if (busy && cyc >= issueCyc) begin
                checkOutput("rndSdAddr", sd_addr, mAddr[gPort]);
                checkOutput("rndSdRw", sd_rw, mRw[gPort]);
                checkOutput("rndSdData", sd_data_in, mData[gPort]);
                checkOutput("rndSdMask", sd_wmask, mMask[gPort]);
            end

            if (!busy) begin
                v0 = mPend[0];
                v1 = mPend[1];
                if (v0 || v1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (v0 && v1) p = 1 - lastG;
                    else p = v0 ? 0 : 1;
`else
                    p = v0 ? 0 : 1;
`endif
                    lastG    = p;
                    gPort    = p;
                    busy     = 1'b1;
                    issueCyc = cyc + 1;
                    lat      = $urandom_range(1, MAXW + 3);
                    rdata    = $urandom;
                    doneCyc  = issueCyc + 1 + ((lat < MAXW) ? lat : MAXW);
                end
            end

            for (int q = 0; q < 2; q++) begin
                vIn = ($urandom_range(0, 5) == 0);
                a = $urandom; d = $urandom; r = 1'($urandom_range(0, 1)); m = 4'($urandom_range(0, 15));
                driveReq(q, a, r, d, m, vIn);
                if (vIn) begin
                    if (mPend[q]) ovNext = 1'b1;
                    else begin
                        mPend[q] = 1'b1; mAddr[q] = a; mData[q] = d; mRw[q] = r; mMask[q] = m;
                    end
                end
            end

            inWait = busy && cyc > issueCyc && cyc < doneCyc;
            if (inWait && lat <= MAXW && cyc == issueCyc + lat) begin
                sd_done = 1'b1; sd_data_out = rdata;
            end else if (!inWait && $urandom_range(0, 7) == 0) begin
                sd_done = 1'b1; sd_data_out = $urandom;
            end else begin
                sd_done = 1'b0; sd_data_out = $urandom;
            end
            tick();
        end
        idleInputs();
    endtask

    initial begin
        int c, k, x, firstPort, secondPort;
        logic [31:0] firstAddr, secondAddr;

        vecs[0] = '{1, 32'h0000_0100, 1'b1, 32'h00AA_BBCC, 4'hF, 5,  32'h1234_5678, 6, 32'h1234_5678, 1'b0};
        vecs[1] = '{0, 32'h0000_2000, 1'b0, 32'h0000_0000, 4'h0, 3,  32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1, 32'h0000_3004, 1'b0, 32'h5555_AAAA, 4'h5, 1,  32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{0, 32'h0000_4008, 1'b1, 32'h0102_0304, 4'hA, 8,  32'h0BAD_F00D, 9, 32'h0BAD_F00D, 1'b0};
        vecs[4] = '{0, 32'h0000_500C, 1'b0, 32'h0000_0000, 4'h0, 9,  32'h7777_7777, 9, 32'h0000_0000, 1'b1};
        vecs[5] = '{1, 32'h0000_6010, 1'b1, 32'hFFFF_0000, 4'hC, 20, 32'h8888_8888, 9, 32'h0000_0000, 1'b1};

        driveReq(0, '0, 1'b0, '0, '0, 1'b0);
        driveReq(1, '0, 1'b0, '0, '0, 1'b0);
        doReset();
        checkOutput("rstSdValid", sd_in_valid, 0);
        checkOutput("rstSdAddr", sd_addr, 0);
        checkOutput("rstDone0", rq0_done, 0);
        checkOutput("rstDone1", rq1_done, 0);
        checkOutput("rstTimeout", err_timeout, 0);
        checkOutput("rstOverflow", err_overflow, 0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Simultaneous requests after a port-0 grant; round robin then favours port 1.
        doReset();
        pulseRequest(0, 32'h0000_0A00, 1'b0, 32'h0, 4'h0);
        awaitIssue(1, c);
        completeTxn(0, 2, 32'h0000_0001, k, x);
        driveReq(0, 32'h0000_0B00, 1'b1, 32'h0B0B_0B0B, 4'h3, 1'b1);
        driveReq(1, 32'h0000_0C00, 1'b0, 32'h0000_0000, 4'h0, 1'b1);
        tick();
        rq0_in_valid = 1'b0; rq1_in_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        firstPort = 1; firstAddr = 32'h0000_0C00; secondPort = 0; secondAddr = 32'h0000_0B00;
`else
        firstPort = 0; firstAddr = 32'h0000_0B00; secondPort = 1; secondAddr = 32'h0000_0C00;
`endif
        awaitIssue(1, c);
        checkOutput("simulIssueLat", c, 2);
        checkOutput("simulFirstAddr", sd_addr, firstAddr);
        completeTxn(firstPort, 3, 32'hAAAA_0001, k, x);
        checkOutput("simulFirstDone", k, 4);
        awaitIssue(0, c);
        checkOutput("simulSecondLat", c, 1);
        checkOutput("simulSecondAddr", sd_addr, secondAddr);
        completeTxn(secondPort, 1, 32'hAAAA_0002, k, x);
        checkOutput("simulSecondDone", k, 2);
        checkOutput("simulSecondData", (secondPort == 0) ? rq0_data_out : rq1_data_out, 32'hAAAA_0002);

        // Overflow: second pulse while pending is dropped and only one transaction runs.
        doReset();
        pulseRequest(1, 32'h0000_0300, 1'b1, 32'h3333_3333, 4'hF);
        pulseRequest(1, 32'h0000_0400, 1'b1, 32'h4444_4444, 4'hF);
        checkOutput("ovfFlag", err_overflow, 1);
        awaitIssue(2, c);
        checkOutput("ovfIssueLat", c, 2);
        checkOutput("ovfAddr", sd_addr, 32'h0000_0300);
        completeTxn(1, 2, 32'h0, k, x);
        x = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sd_in_valid) x++;
        end
        checkOutput("ovfOneTxn", x, 0);
        checkOutput("ovfSticky", err_overflow, 1);

        // Timeout on port 0 with port 1 queued behind it.
        doReset();
        pulseRequest(0, 32'h0000_0500, 1'b0, 32'h0, 4'h0);
        pulseRequest(1, 32'h0000_0600, 1'b0, 32'h0, 4'h0);
        awaitIssue(2, c);
        checkOutput("toAddr", sd_addr, 32'h0000_0500);
        completeTxn(0, 100, 32'h0, k, x);
        checkOutput("toDoneLat", k, MAXW + 1);
        checkOutput("toFlag", err_timeout, 1);
        checkOutput("toData", rq0_data_out, 0);
        awaitIssue(0, c);
        checkOutput("toNextLat", c, 1);
        checkOutput("toNextAddr", sd_addr, 32'h0000_0600);
        completeTxn(1, 2, 32'h6666_6666, k, x);
        checkOutput("toNextData", rq1_data_out, 32'h6666_6666);

        // Reset in WAIT abandons the transaction; pulses during reset are discarded.
        doReset();
        pulseRequest(0, 32'h0000_0010, 1'b0, 32'h0, 4'h0);
        awaitIssue(1, c);
        completeTxn(0, 2, 32'h1111_2222, k, x);
        pulseRequest(0, 32'h0000_0700, 1'b1, 32'h7070_7070, 4'hF);
        awaitIssue(1, c);
        pulseRequest(0, 32'h0000_0800, 1'b1, 32'h0, 4'hF);
        checkOutput("rstwPreOvf", err_overflow, 1);
        reset = 1'b0;
        rq1_in_valid = 1'b1;
        tick();
        rq1_in_valid = 1'b0;
        reset = 1'b1;
        checkOutput("rstwSdValid", sd_in_valid, 0);
        checkOutput("rstwSdRw", sd_rw, 0);
        checkOutput("rstwSdAddr", sd_addr, 0);
        checkOutput("rstwSdData", sd_data_in, 0);
        checkOutput("rstwSdMask", sd_wmask, 0);
        checkOutput("rstwOut0", rq0_data_out, 0);
        checkOutput("rstwOut1", rq1_data_out, 0);
        checkOutput("rstwOverflow", err_overflow, 0);
        checkOutput("rstwTimeout", err_timeout, 0);
        sd_done = 1'b1;
        sd_data_out = 32'h9999_9999;
        x = 0;
        c = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            sd_done = 1'b0;
            if (rq0_done || rq1_done) x++;
            if (sd_in_valid) c++;
        end
        checkOutput("rstwNoDone", x, 0);
        checkOutput("rstwNoIssue", c, 0);

        doReset();
        runRandom(3000);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
